// File: rtl/iteration_counter_csg.sv
// Multi-dimensional loop-index counter for the CSG path: odometer-ordered
// indices, per-dimension upper-bound flags, and busy/done status.
module iteration_counter_csg #(
  parameter int DIMENSION = 3,
  parameter int WIDTH     = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       step,
  input  logic                       abort,
  input  logic [DIMENSION*WIDTH-1:0] bounds,
  output logic [DIMENSION*WIDTH-1:0] index,
  output logic [0:DIMENSION-1]       at_max,
  output logic                       busy,
  output logic                       done
);

  localparam int TW = DIMENSION * WIDTH;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t                state_r, state_s;
  logic [TW-1:0]         bound_r, bound_s;
  logic [TW-1:0]         index_r, index_s;
  logic [TW-1:0]         odo_s;
  logic                  done_r, done_s;
  logic                  busy_s;
  logic [0:DIMENSION-1]  at_max_s;
  logic                  all_max_s;
  logic                  carry_s;

  assign busy_s = (state_r == RUN);

  // Per-dimension bound comparison, gated by busy so IDLE never reports a match.
  always_comb begin
    at_max_s = {DIMENSION{1'b0}};
    for (int i = 0; i < DIMENSION; i++) begin
      at_max_s[i] = busy_s & (index_r[i*WIDTH +: WIDTH] == bound_r[i*WIDTH +: WIDTH]);
    end
    all_max_s = &at_max_s;
  end

  // Odometer successor: wrap each saturated dimension and carry onward.
  always_comb begin
    odo_s   = index_r;
    carry_s = 1'b1;
    for (int i = 0; i < DIMENSION; i++) begin
      if (carry_s) begin
        if (at_max_s[i]) begin
          odo_s[i*WIDTH +: WIDTH] = {WIDTH{1'b0}};
        end else begin
          odo_s[i*WIDTH +: WIDTH] = index_r[i*WIDTH +: WIDTH] + WIDTH'(1'b1);
          carry_s = 1'b0;
        end
      end else begin
        odo_s[i*WIDTH +: WIDTH] = index_r[i*WIDTH +: WIDTH];
      end
    end
  end

  // Next-state and next-register values for the IDLE/RUN sequencer.
  always_comb begin
    state_s = state_r;
    bound_s = bound_r;
    index_s = index_r;
    done_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          bound_s = bounds;
          index_s = {TW{1'b0}};
          state_s = RUN;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (abort) begin
          index_s = {TW{1'b0}};
          state_s = IDLE;
        end else if (step) begin
          if (all_max_s) begin
            done_s  = 1'b1;
            index_s = {TW{1'b0}};
            state_s = IDLE;
          end else begin
            index_s = odo_s;
          end
        end else begin
          state_s = RUN;
        end
      end
      default: begin
        index_s = {TW{1'b0}};
        state_s = IDLE;
      end
    endcase
  end

  // State, bound, index and done registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      bound_r <= {TW{1'b0}};
      index_r <= {TW{1'b0}};
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      bound_r <= bound_s;
      index_r <= index_s;
      done_r  <= done_s;
    end
  end

  assign index  = index_r;
  assign at_max = at_max_s;
  assign busy   = busy_s;
  assign done   = done_r;

endmodule

// File: tb/tb_iteration_counter_csg.sv
// Directed plus randomized bench for iteration_counter_csg; the reference
// model tracks a linear iteration number and derives indices by mixed radix.
module tb_iteration_counter_csg;

  localparam int D  = 3;
  localparam int W  = 4;
  localparam int TW = D * W;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          step = 1'b0;
  logic          abort = 1'b0;
  logic [TW-1:0] bounds = '0;
  logic [TW-1:0] index;
  logic [0:D-1]  at_max;
  logic          busy;
  logic          done;

  iteration_counter_csg #(.DIMENSION(D), .WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .step(step), .abort(abort),
    .bounds(bounds), .index(index), .at_max(at_max), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  int mb[D];
  int iter = 0;
  bit mbusy = 1'b0;
  bit mdone = 1'b0;

  function automatic int total_iters();
    int t = 1;
    for (int i = 0; i < D; i++) t = t * (mb[i] + 1);
    return t;
  endfunction

  task automatic model_clear();
    mbusy = 1'b0; mdone = 1'b0; iter = 0;
    for (int i = 0; i < D; i++) mb[i] = 0;
  endtask

  task automatic model_update();
    if (reset) begin
      model_clear();
    end else begin
      mdone = 1'b0;
      if (!mbusy) begin
        if (start) begin
          for (int i = 0; i < D; i++) mb[i] = int'(bounds[i*W +: W]);
          iter = 0;
          mbusy = 1'b1;
        end
      end else if (abort) begin
        mbusy = 1'b0; iter = 0;
      end else if (step) begin
        if (iter == total_iters() - 1) begin
          mdone = 1'b1; mbusy = 1'b0; iter = 0;
        end else begin
          iter++;
        end
      end
    end
  endtask

  task automatic check(input string tag);
    logic [TW-1:0] exp_idx;
    logic [0:D-1]  exp_am;
    int rem, digit;
    exp_idx = '0;
    exp_am  = '0;
    rem = iter;
    for (int i = 0; i < D; i++) begin
      digit = rem % (mb[i] + 1);
      rem   = rem / (mb[i] + 1);
      exp_idx[i*W +: W] = W'(digit);
      exp_am[i] = mbusy && (digit == mb[i]);
    end
    vectors++;
    assert (index === exp_idx) else begin
      miscompares++;
      $error("FAIL %s index got %h expected %h", tag, index, exp_idx);
    end
    vectors++;
    assert (at_max === exp_am) else begin
      miscompares++;
      $error("FAIL %s at_max got %b expected %b", tag, at_max, exp_am);
    end
    vectors++;
    assert (busy === mbusy) else begin
      miscompares++;
      $error("FAIL %s busy got %b expected %b", tag, busy, mbusy);
    end
    vectors++;
    assert (done === mdone) else begin
      miscompares++;
      $error("FAIL %s done got %b expected %b", tag, done, mdone);
    end
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_update();
    #1;
    check(tag);
  endtask

  task automatic drive(input logic s, input logic st, input logic ab);
    start = s; step = st; abort = ab;
  endtask

  localparam logic [TW-1:0] B121 = {4'd1, 4'd2, 4'd1};

  int done_seen;
  int budget;

  initial begin
    model_clear();

    // Reset held while toggling controls
    for (int k = 0; k < 4; k++) begin
      drive(k[0], ~k[0], 1'b0);
      bounds = 12'h5A5;
      tick("reset_hold");
    end
    @(negedge clk);
    reset = 1'b0;
    drive(1'b0, 1'b1, 1'b0);
    tick("reset_release");
    tick("reset_release");

    // Full traversal with bounds (1,2,1)
    bounds = B121;
    drive(1'b1, 1'b1, 1'b0);
    tick("trav_start");
    drive(1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 12; k++) tick("trav_step");
    drive(1'b0, 1'b0, 1'b0);
    tick("trav_idle");

    // Stalls, mid-run start and bound change
    drive(1'b1, 1'b0, 1'b0);
    tick("stall_start");
    done_seen = 0;
    budget = 0;
    while (done_seen == 0 && budget < 60) begin
      drive(budget == 5, budget[0], 1'b0);
      bounds = (budget > 3) ? 12'hFFF : B121;
      tick("stall_run");
      if (done) done_seen = 1;
      budget++;
    end
    vectors++;
    assert (done_seen == 1) else begin
      miscompares++;
      $error("FAIL stall_done_timeout got %0d expected 1", done_seen);
    end

    // All-zero bounds: single step completes
    bounds = '0;
    drive(1'b1, 1'b0, 1'b0);
    tick("zero_start");
    drive(1'b0, 1'b1, 1'b0);
    tick("zero_step");
    tick("zero_after");

    // Maximum inner bound (15,0,0)
    bounds = {4'd0, 4'd0, 4'd15};
    drive(1'b1, 1'b0, 1'b0);
    tick("max_start");
    drive(1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 16; k++) tick("max_step");
    drive(1'b0, 1'b0, 1'b0);
    tick("max_idle");

    // Abort at (1,1,0), then restart
    bounds = B121;
    drive(1'b1, 1'b0, 1'b0);
    tick("abort_start");
    drive(1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) tick("abort_pre");
    drive(1'b0, 1'b1, 1'b1);
    tick("abort_hit");
    drive(1'b1, 1'b0, 1'b0);
    tick("abort_restart");

    // Asynchronous reset at (0,2,0)
    drive(1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) tick("areset_pre");
    drive(1'b0, 1'b0, 1'b0);
    #2;
    reset = 1'b1;
    model_clear();
    #1;
    check("areset_immediate");
    @(negedge clk);
    reset = 1'b0;
    tick("areset_after");

    // Back-to-back runs: restart in the done cycle
    bounds = {4'd0, 4'd1, 4'd1};
    drive(1'b1, 1'b0, 1'b0);
    tick("b2b_start");
    drive(1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) tick("b2b_run");
    drive(1'b1, 1'b1, 1'b0);
    tick("b2b_restart");
    drive(1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) tick("b2b_run2");

    // Randomized traffic
    for (int k = 0; k < 3000; k++) begin
      drive(($urandom % 4) == 0, ($urandom % 4) != 0, ($urandom % 40) == 0);
      for (int i = 0; i < D; i++)
        bounds[i*W +: W] = (($urandom % 16) == 0) ? 4'd15 : W'($urandom_range(0, 3));
      tick("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/iteration_counter_csg.md
# iteration_counter_csg

Multi-dimensional loop-index counter for the Global Controller's control-signal generation (CSG) path. It holds one index register per loop dimension, advances the indices in nested odometer order on each step, and drives a per-dimension "at upper bound" vector. That vector feeds the downstream reduction-AND stage, which detects the last iteration. It also produces busy/done status for the controller sequencer.

## Interface
- DIMENSION, 3, number of loop dimensions; dimension 0 is innermost (fastest-changing).
- WIDTH, 8, bit width of each index and bound.

- clk  input  1  system clock, rising-edge active.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  load bounds and begin iteration; honored only in IDLE.
- step  input  1  advance indices by one iteration; honored only in RUN.
- abort  input  1  synchronous abort; returns to IDLE with no done pulse.
- bounds  input  DIMENSION*WIDTH  inclusive upper bound per dimension; dimension i occupies bits [i*WIDTH +: WIDTH]; sampled on accepted start only.
- index  output  DIMENSION*WIDTH  current index per dimension, same packing as bounds.
- at_max  output  [0:DIMENSION-1]  bit i = busy AND index[i] == bound[i]; connects directly to the reduction-AND input.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse after the final iteration's step.

## Operation
- The FSM has two states, IDLE and RUN. Reset enters IDLE.
- IDLE + start: latch bounds into internal bound registers, clear all indices to 0, go to RUN. Step is ignored in that cycle.
- RUN + abort: go to IDLE and clear indices. No done pulse. Abort has priority over step.
- RUN + step, not all at_max: odometer increment.
  - Dimension 0 increments.
  - A dimension whose index equals its bound wraps to 0 and carries into the next dimension.
  - Carry stops at the first dimension below its bound; that dimension increments by 1.
  - Higher dimensions hold their values.
- RUN + step with all at_max set (final iteration): pulse done, clear indices, go to IDLE.
- RUN with no step: all registers hold.
- start while in RUN: ignored. Bounds changes while in RUN: ignored, because bounds are latched.
- A bound of 0 means that dimension always shows at_max in RUN and always wraps (trip count 1).
- Total iterations = product over i of (bound[i]+1). With all bounds 0, a single step completes the loop.
- Index arithmetic is unsigned WIDTH bits. Because comparison is against the inclusive bound, the register never overflows. A bound of 2^WIDTH-1 is legal.
- at_max is combinational from the index and bound registers plus the busy state. No input feeds it combinationally.

## Timing
- Reset values: index = 0, bound registers = 0, busy = 0, done = 0, at_max = all 0, state = IDLE.
- Reset asserted mid-iteration clears everything asynchronously. After release the block waits for a new start.
- start accepted at edge N: busy = 1 and index = 0 from cycle N+1. at_max is valid in cycle N+1.
- step accepted at edge N: the new index and at_max are visible in cycle N+1. The step-to-index latency is 1 cycle.
- Final step at edge N: done = 1 and busy = 0 in cycle N+1 only. done returns to 0 at edge N+1.
- A new start is accepted in the same cycle that done is high, since the block is already in IDLE. Throughput is one step per cycle sustained.
- Downstream last-iteration detection (AND of at_max) is valid in the same cycle as the index it describes.

## Test plan
- Reset values: DIMENSION=3, WIDTH=4. Hold reset and toggle start/step → all outputs 0. Release reset → outputs stay 0 until start.
- Full traversal: bounds = (d0=1, d1=2, d2=1); start, then step every cycle.
  - Index sequence is (0,0,0), (1,0,0), (0,1,0), … , (1,2,1): 12 iterations.
  - at_max = 3'b111 only at (1,2,1).
  - The 12th step gives done=1 for exactly 1 cycle and busy=0.
- Stalls and ignored inputs: same bounds, with step asserted on alternate cycles and start pulsed mid-run.
  - Index holds on idle cycles.
  - The mid-run start has no effect.
  - Bounds changed mid-run have no effect.
  - done still follows the 12th accepted step.
- Zero and maximum bounds:
  - bounds = (0,0,0): one step → done.
  - bounds = (15,0,0): index d0 counts 0..15 with at_max[1:2] constantly 1. done follows step 16. No overflow.
- Abort and reset mid-run:
  - Abort at index (1,1,0) → IDLE, index=0, no done. A following start restarts from (0,0,0).
  - Asynchronous reset at (0,2,0) → immediate clear.
- Back-to-back runs: start asserted in the done cycle → busy=1 next cycle with index=0 and no lost step.
